// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// default byte width and a sizing helper used for index/counter widths.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    localparam int DEFAULT_WORD_LEN = 8;

    // Bits needed to index 'value' items, never less than one.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits++;
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping modulo N_REQ, so indices >= N_REQ are never produced.
module uart_tx_scheduler_rr_pick
    import uart_tx_scheduler_pkg::*;
#(
    parameter int   N_REQ = 4,
    localparam int  GW    = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [GW-1:0]    rr_ptr,
    output logic [GW-1:0]    pick,
    output logic             any_valid
);

    logic [GW-1:0] cand;

    // Scan from the far end back toward rr_ptr so the closest valid index wins.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_ptr) + k) % N_REQ);
            if (req_valid[cand]) begin
                pick      = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between N_REQ byte sources using round-robin
// arbitration with bounded bursts, a one-cycle load strobe and a start timeout.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int   WORD_LEN      = DEFAULT_WORD_LEN,
    parameter int   N_REQ         = 4,
    parameter int   MAX_BURST     = 4,
    parameter int   START_TIMEOUT = 64,
    localparam int  GW            = clog2_min1(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ*WORD_LEN-1:0] req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [WORD_LEN-1:0]       tx_data,
    output logic                      tx_valid,
    input  logic                      tx_busy,
    output logic [GW-1:0]             grant_id,
    output logic                      arb_busy,
    output logic                      tx_timeout_err
);

    localparam int            TW         = clog2_min1(START_TIMEOUT);
    localparam int            BW         = clog2_min1(MAX_BURST);
    localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] LAST_IDX   = GW'(N_REQ - 1);

    sched_state_t          state, state_n;
    logic [GW-1:0]         rr_ptr, rr_ptr_n;
    logic [GW-1:0]         grant_n;
    logic [BW-1:0]         burst_cnt, burst_n;
    logic [TW-1:0]         timer, timer_n;
    logic [WORD_LEN-1:0]   tx_data_n;
    logic                  last_q, last_n;
    logic [GW-1:0]         pick;
    logic                  any_valid;
    logic [GW-1:0]         src_sel;
    logic [GW-1:0]         next_ptr;
    logic [WORD_LEN-1:0]   load_data;
    logic                  load_last;

    uart_tx_scheduler_rr_pick #(
        .N_REQ     (N_REQ)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .pick      (pick),
        .any_valid (any_valid)
    );

    // The byte is captured on the way into SEND so tx_data is already stable
    // in the same cycle as the tx_valid strobe.
    assign src_sel   = (state == IDLE) ? pick : grant_id;
    assign load_data = req_data[int'(src_sel)*WORD_LEN +: WORD_LEN];
    assign load_last = req_last[src_sel];
    assign next_ptr  = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
    assign arb_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            timer     <= '0;
            tx_data   <= '0;
            last_q    <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            grant_id  <= grant_n;
            burst_cnt <= burst_n;
            timer     <= timer_n;
            tx_data   <= tx_data_n;
            last_q    <= last_n;
        end
    end

    always_comb begin
        state_n        = state;
        rr_ptr_n       = rr_ptr;
        grant_n        = grant_id;
        burst_n        = burst_cnt;
        timer_n        = timer;
        tx_data_n      = tx_data;
        last_n         = last_q;
        tx_valid       = 1'b0;
        req_ready      = '0;
        tx_timeout_err = 1'b0;

        case (state)
            IDLE: begin
                // A busy transmitter here may be a frame left over from before reset.
                if (!tx_busy && any_valid) begin
                    grant_n   = pick;
                    burst_n   = '0;
                    tx_data_n = load_data;
                    last_n    = load_last;
                    state_n   = SEND;
                end
            end
            SEND: begin
                tx_valid           = 1'b1;
                req_ready[grant_id] = 1'b1;
                timer_n            = '0;
                state_n            = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    tx_timeout_err = 1'b1;
                    rr_ptr_n       = next_ptr;
                    state_n        = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (!last_q && (burst_cnt < BURST_LAST) && req_valid[grant_id]) begin
                        burst_n   = burst_cnt + 1'b1;
                        tx_data_n = load_data;
                        last_n    = load_last;
                        state_n   = SEND;
                    end else begin
                        rr_ptr_n = next_ptr;
                        state_n  = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
